reservation_station: RTL and testbench

Out-of-order issue queue that feeds the execute ALU. It accepts decoded ALU/branch/jump instructions from dispatch with possibly-unresolved operands tagged by ROB nick. It snoops the CDB broadcasts from the ALU and the load/store buffer to wake waiting operands, then issues one fully-ready instruction per cycle to the ALU as registered `oRS_*` outputs.

---
 rtl/reservation_station.sv | 181 ++++++++++++++++++
 tb/tb_reservation_station.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station
//   Out-of-order issue queue in front of the execute ALU. Holds DEPTH
//   decoded instructions whose operands may still be pending on a ROB nick.
//   Snoops the ALU and load/store-buffer CDB broadcasts to wake operands.
//   Issues the lowest-index fully-ready entry each cycle through registered
//   oRS_* outputs.
// Ports
//   clk, rst (async active-low), rdy (global enable), iROB_clr (flush)
//   iDP_*   : dispatch request (instruction fields + operand ready/data/nick)
//   oRS_full: all entries busy (combinational from busy bits)
//   iEX_*   : ALU CDB broadcast        iLSB_* : load/store CDB broadcast
//   oRS_*   : issued instruction (oRS_en is a one-cycle valid pulse)
module reservation_station #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        iROB_clr,
   input  logic        iDP_en,
   input  logic [31:0] iDP_pc,
   input  logic [5:0]  iDP_op,
   input  logic [31:0] iDP_imm,
   input  logic [3:0]  iDP_rd_nick,
   input  logic        iDP_rs1_rdy,
   input  logic [31:0] iDP_rs1_dt,
   input  logic [3:0]  iDP_rs1_nick,
   input  logic        iDP_rs2_rdy,
   input  logic [31:0] iDP_rs2_dt,
   input  logic [3:0]  iDP_rs2_nick,
   output logic        oRS_full,
   input  logic        iEX_en,
   input  logic [3:0]  iEX_nick,
   input  logic [31:0] iEX_dt,
   input  logic        iLSB_en,
   input  logic [3:0]  iLSB_nick,
   input  logic [31:0] iLSB_dt,
   output logic        oRS_en,
   output logic [31:0] oRS_pc,
   output logic [5:0]  oRS_op,
   output logic [31:0] oRS_imm,
   output logic [3:0]  oRS_rd_nick,
   output logic [31:0] oRS_rs1_dt,
   output logic [31:0] oRS_rs2_dt
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic        busy;
      logic [31:0] pc;
      logic [5:0]  op;
      logic [31:0] imm;
      logic [3:0]  rd_nick;
      logic        rs1_rdy;
      logic [31:0] rs1_dt;
      logic [3:0]  rs1_nick;
      logic        rs2_rdy;
      logic [31:0] rs2_dt;
      logic [3:0]  rs2_nick;
   } entry_t;

   typedef struct packed {
      logic        rdy;
      logic [31:0] dt;
   } opnd_t;

   entry_t          ent [DEPTH];
   opnd_t           wk1 [DEPTH];
   opnd_t           wk2 [DEPTH];
   opnd_t           dp1, dp2;
   entry_t          dp_ent;
   logic [DEPTH-1:0] busy_vec, cand_vec;
   logic [IW-1:0]   free_idx, sel_idx;
   logic            has_free, has_sel;

   // CDB snoop for one operand; the ALU bus has priority over the LSB bus
   // when both carry the same nick.
   function automatic opnd_t snoop(input logic r, input logic [31:0] dt,
                                   input logic [3:0] nick);
      opnd_t o;
      o.rdy = r;
      o.dt  = dt;
      if (!r) begin
         if (iEX_en && iEX_nick == nick) begin
            o.rdy = 1'b1;
            o.dt  = iEX_dt;
         end else if (iLSB_en && iLSB_nick == nick) begin
            o.rdy = 1'b1;
            o.dt  = iLSB_dt;
         end
      end
      return o;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         busy_vec[i] = ent[i].busy;
         cand_vec[i] = ent[i].busy & ent[i].rs1_rdy & ent[i].rs2_rdy;
         wk1[i]      = snoop(ent[i].rs1_rdy, ent[i].rs1_dt, ent[i].rs1_nick);
         wk2[i]      = snoop(ent[i].rs2_rdy, ent[i].rs2_dt, ent[i].rs2_nick);
      end
   end

   // Lowest-index free slot and lowest-index ready candidate, both taken
   // from the pre-edge state, so a slot freed by issue is reused next cycle.
   always_comb begin
      free_idx = '0;
      has_free = 1'b0;
      sel_idx  = '0;
      has_sel  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_vec[i]) begin
            free_idx = IW'(i);
            has_free = 1'b1;
         end
         if (cand_vec[i]) begin
            sel_idx = IW'(i);
            has_sel = 1'b1;
         end
      end
   end

   assign oRS_full = &busy_vec;

   // New entry, with same-cycle CDB forwarding folded in.
   always_comb begin
      dp1             = snoop(iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick);
      dp2             = snoop(iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick);
      dp_ent.busy     = 1'b1;
      dp_ent.pc       = iDP_pc;
      dp_ent.op       = iDP_op;
      dp_ent.imm      = iDP_imm;
      dp_ent.rd_nick  = iDP_rd_nick;
      dp_ent.rs1_rdy  = dp1.rdy;
      dp_ent.rs1_dt   = dp1.dt;
      dp_ent.rs1_nick = iDP_rs1_nick;
      dp_ent.rs2_rdy  = dp2.rdy;
      dp_ent.rs2_dt   = dp2.dt;
      dp_ent.rs2_nick = iDP_rs2_nick;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         oRS_en      <= 1'b0;
         oRS_pc      <= '0;
         oRS_op      <= '0;
         oRS_imm     <= '0;
         oRS_rd_nick <= '0;
         oRS_rs1_dt  <= '0;
         oRS_rs2_dt  <= '0;
      end else if (rdy) begin
         if (iROB_clr) begin
            for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
            oRS_en <= 1'b0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent[i].busy) begin
                  ent[i].rs1_rdy <= wk1[i].rdy;
                  ent[i].rs1_dt  <= wk1[i].dt;
                  ent[i].rs2_rdy <= wk2[i].rdy;
                  ent[i].rs2_dt  <= wk2[i].dt;
               end
            end
            oRS_en <= has_sel;
            if (has_sel) begin
               oRS_pc            <= ent[sel_idx].pc;
               oRS_op            <= ent[sel_idx].op;
               oRS_imm           <= ent[sel_idx].imm;
               oRS_rd_nick       <= ent[sel_idx].rd_nick;
               oRS_rs1_dt        <= ent[sel_idx].rs1_dt;
               oRS_rs2_dt        <= ent[sel_idx].rs2_dt;
               ent[sel_idx].busy <= 1'b0;
            end
            // free_idx is never a busy slot, so this cannot collide with
            // the wakeup or issue updates above.
            if (iDP_en && has_free) ent[free_idx] <= dp_ent;
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station
//   Directed bench for reservation_station (DEPTH=8). Expected issues are
//   pushed to a scoreboard queue as stimulus is driven and popped whenever
//   the DUT raises oRS_en.
module tb_reservation_station;
   logic        clk = 1'b0;
   logic        rst, rdy, iROB_clr, iDP_en;
   logic [31:0] iDP_pc, iDP_imm, iDP_rs1_dt, iDP_rs2_dt;
   logic [5:0]  iDP_op;
   logic [3:0]  iDP_rd_nick, iDP_rs1_nick, iDP_rs2_nick;
   logic        iDP_rs1_rdy, iDP_rs2_rdy;
   logic        oRS_full;
   logic        iEX_en, iLSB_en;
   logic [3:0]  iEX_nick, iLSB_nick;
   logic [31:0] iEX_dt, iLSB_dt;
   logic        oRS_en;
   logic [31:0] oRS_pc, oRS_imm, oRS_rs1_dt, oRS_rs2_dt;
   logic [5:0]  oRS_op;
   logic [3:0]  oRS_rd_nick;

   typedef struct packed {
      logic [31:0] pc;
      logic [5:0]  op;
      logic [31:0] imm;
      logic [3:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
   } issue_t;

   issue_t q[$];
   int     npass = 0;
   int     ntotal = 0;
   bit     sb_on = 1'b1;

   reservation_station #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
      .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_op(iDP_op), .iDP_imm(iDP_imm),
      .iDP_rd_nick(iDP_rd_nick),
      .iDP_rs1_rdy(iDP_rs1_rdy), .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs1_nick(iDP_rs1_nick),
      .iDP_rs2_rdy(iDP_rs2_rdy), .iDP_rs2_dt(iDP_rs2_dt), .iDP_rs2_nick(iDP_rs2_nick),
      .oRS_full(oRS_full),
      .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
      .iLSB_en(iLSB_en), .iLSB_nick(iLSB_nick), .iLSB_dt(iLSB_dt),
      .oRS_en(oRS_en), .oRS_pc(oRS_pc), .oRS_op(oRS_op), .oRS_imm(oRS_imm),
      .oRS_rd_nick(oRS_rd_nick), .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic push(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                       input logic [3:0] rd, input logic [31:0] d1, input logic [31:0] d2);
      issue_t e;
      e.pc = pc; e.op = op; e.imm = imm; e.rd = rd; e.d1 = d1; e.d2 = d2;
      q.push_back(e);
   endtask

   task automatic check_issue();
      issue_t e;
      if (sb_on && oRS_en) begin
         ntotal++;
         assert (q.size() > 0) npass++;
         else $error("FAIL unexpected_issue: got pc %h expected no issue", oRS_pc);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("iss_pc", oRS_pc, e.pc);
            chk("iss_op", 32'(oRS_op), 32'(e.op));
            chk("iss_imm", oRS_imm, e.imm);
            chk("iss_rd", 32'(oRS_rd_nick), 32'(e.rd));
            chk("iss_rs1", oRS_rs1_dt, e.d1);
            chk("iss_rs2", oRS_rs2_dt, e.d2);
         end
      end
   endtask

   // One clock: inputs set beforehand are consumed at the edge, pulses are
   // cleared and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      iDP_en = 1'b0; iEX_en = 1'b0; iLSB_en = 1'b0; iROB_clr = 1'b0;
      check_issue();
   endtask

   task automatic dp(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                     input logic [3:0] rd,
                     input logic r1, input logic [31:0] d1, input logic [3:0] n1,
                     input logic r2, input logic [31:0] d2, input logic [3:0] n2);
      iDP_en = 1'b1; iDP_pc = pc; iDP_op = op; iDP_imm = imm; iDP_rd_nick = rd;
      iDP_rs1_rdy = r1; iDP_rs1_dt = d1; iDP_rs1_nick = n1;
      iDP_rs2_rdy = r2; iDP_rs2_dt = d2; iDP_rs2_nick = n2;
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; iROB_clr = 1'b0; iDP_en = 1'b0;
      iDP_pc = '0; iDP_op = '0; iDP_imm = '0; iDP_rd_nick = '0;
      iDP_rs1_rdy = 1'b0; iDP_rs1_dt = '0; iDP_rs1_nick = '0;
      iDP_rs2_rdy = 1'b0; iDP_rs2_dt = '0; iDP_rs2_nick = '0;
      iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0;
      iLSB_en = 1'b0; iLSB_nick = '0; iLSB_dt = '0;

      // reset state
      #12;
      chk("rst_en", 32'(oRS_en), 0);
      chk("rst_full", 32'(oRS_full), 0);
      chk("rst_pc", oRS_pc, 0);
      chk("rst_rs1", oRS_rs1_dt, 0);
      rst = 1'b1;
      tick();

      // single ready op: issue one cycle after dispatch
      dp(32'h100, 6'd1, 32'h0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
      push(32'h100, 6'd1, 32'h0, 4'd3, 32'd5, 32'd7);
      tick();
      chk("single_lat0", 32'(oRS_en), 0);
      tick();
      chk("single_en", 32'(oRS_en), 1);
      tick();
      chk("single_drop", 32'(oRS_en), 0);

      // wakeup from ALU bus
      dp(32'h110, 6'd2, 32'h11, 4'd4, 1'b0, 32'hDEAD, 4'd2, 1'b1, 32'd1, 4'd0);
      tick(); tick();
      iEX_en = 1'b1; iEX_nick = 4'd2; iEX_dt = 32'h10;
      push(32'h110, 6'd2, 32'h11, 4'd4, 32'h10, 32'd1);
      tick();
      chk("ex_wake_same", 32'(oRS_en), 0);
      tick();
      chk("ex_wake_iss", 32'(oRS_en), 1);
      tick();

      // wakeup from LSB bus on rs2
      dp(32'h120, 6'd3, 32'h12, 4'd5, 1'b1, 32'd9, 4'd0, 1'b0, 32'hBEEF, 4'd6);
      tick(); tick();
      iLSB_en = 1'b1; iLSB_nick = 4'd6; iLSB_dt = 32'h20;
      push(32'h120, 6'd3, 32'h12, 4'd5, 32'd9, 32'h20);
      tick();
      chk("lsb_wake_same", 32'(oRS_en), 0);
      tick();
      chk("lsb_wake_iss", 32'(oRS_en), 1);
      tick();

      // forward at dispatch
      dp(32'h130, 6'd4, 32'h13, 4'd6, 1'b0, 32'h0, 4'd7, 1'b1, 32'd2, 4'd0);
      iEX_en = 1'b1; iEX_nick = 4'd7; iEX_dt = 32'h30;
      push(32'h130, 6'd4, 32'h13, 4'd6, 32'h30, 32'd2);
      tick();
      tick();
      chk("fwd_iss", 32'(oRS_en), 1);
      tick();

      // both buses carry the same nick: ALU data wins
      dp(32'h140, 6'd5, 32'h14, 4'd7, 1'b0, 32'h0, 4'd9, 1'b1, 32'd3, 4'd0);
      tick();
      iEX_en = 1'b1; iEX_nick = 4'd9; iEX_dt = 32'hAA;
      iLSB_en = 1'b1; iLSB_nick = 4'd9; iLSB_dt = 32'hBB;
      push(32'h140, 6'd5, 32'h14, 4'd7, 32'hAA, 32'd3);
      tick();
      tick();
      chk("prio_iss", 32'(oRS_en), 1);
      tick();

      // ordering: fill 8 entries, entry i waiting on nick i
      for (int i = 0; i < 8; i++) begin
         chk("fill_notfull", 32'(oRS_full), 0);
         dp(32'h200 + 32'(4 * i), 6'(i + 1), 32'h1000 + 32'(i), 4'(i),
            1'b0, 32'h0, 4'(i), 1'b1, 32'h7000 + 32'(i), 4'd0);
         tick();
      end
      chk("full_set", 32'(oRS_full), 1);
      dp(32'h999, 6'd63, 32'h0, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
      tick();
      chk("full_drop", 32'(oRS_full), 1);
      iEX_en = 1'b1; iEX_nick = 4'd5; iEX_dt = 32'h55;
      iLSB_en = 1'b1; iLSB_nick = 4'd2; iLSB_dt = 32'h22;
      push(32'h208, 6'd3, 32'h1002, 4'd2, 32'h22, 32'h7002);
      push(32'h214, 6'd6, 32'h1005, 4'd5, 32'h55, 32'h7005);
      tick();
      chk("ord_wake", 32'(oRS_en), 0);
      tick();
      chk("ord_first", 32'(oRS_rd_nick), 2);
      chk("ord_full_fall", 32'(oRS_full), 0);
      tick();
      chk("ord_second", 32'(oRS_rd_nick), 5);

      // refill to 7 busy, then issue + dispatch on the same edge
      dp(32'h300, 6'd10, 32'h30, 4'd8, 1'b0, 32'h0, 4'd10, 1'b1, 32'd0, 4'd0);
      tick();
      chk("sim_seven", 32'(oRS_full), 0);
      iEX_en = 1'b1; iEX_nick = 4'd0; iEX_dt = 32'h100;
      push(32'h200, 6'd1, 32'h1000, 4'd0, 32'h100, 32'h7000);
      tick();
      dp(32'h310, 6'd11, 32'h31, 4'd9, 1'b0, 32'h0, 4'd11, 1'b1, 32'd0, 4'd0);
      tick();
      chk("sim_issue", 32'(oRS_en), 1);
      chk("sim_occ", 32'(oRS_full), 0);
      dp(32'h320, 6'd12, 32'h32, 4'd10, 1'b0, 32'h0, 4'd12, 1'b1, 32'd0, 4'd0);
      tick();
      chk("sim_full", 32'(oRS_full), 1);

      // flush overrides an issuable entry and a same-edge dispatch
      iEX_en = 1'b1; iEX_nick = 4'd1; iEX_dt = 32'h11;
      tick();
      iROB_clr = 1'b1;
      dp(32'h330, 6'd13, 32'h33, 4'd11, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
      tick();
      chk("flush_en", 32'(oRS_en), 0);
      chk("flush_full", 32'(oRS_full), 0);
      iEX_en = 1'b1; iEX_nick = 4'd3; iEX_dt = 32'h3;
      iLSB_en = 1'b1; iLSB_nick = 4'd10; iLSB_dt = 32'h4;
      tick();
      tick();
      chk("flush_quiet", 32'(oRS_en), 0);

      // rdy low freezes outputs and blocks dispatch
      dp(32'h400, 6'd3, 32'h44, 4'd5, 1'b1, 32'hA1, 4'd0, 1'b1, 32'hA2, 4'd0);
      push(32'h400, 6'd3, 32'h44, 4'd5, 32'hA1, 32'hA2);
      tick();
      tick();
      chk("frz_pre_en", 32'(oRS_en), 1);
      sb_on = 1'b0;
      rdy = 1'b0;
      dp(32'h500, 6'd7, 32'h55, 4'd6, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_en", 32'(oRS_en), 1);
         chk("frz_pc", oRS_pc, 32'h400);
      end
      rdy = 1'b1;
      sb_on = 1'b1;
      tick();
      chk("unfrz_en", 32'(oRS_en), 0);
      tick();
      chk("unfrz_nodp", 32'(oRS_en), 0);

      // async reset between edges while issuing
      dp(32'h600, 6'd8, 32'h66, 4'd12, 1'b0, 32'h0, 4'd13, 1'b1, 32'd0, 4'd0);
      tick();
      dp(32'h610, 6'd9, 32'h67, 4'd13, 1'b1, 32'h61, 4'd0, 1'b1, 32'h62, 4'd0);
      push(32'h610, 6'd9, 32'h67, 4'd13, 32'h61, 32'h62);
      tick();
      tick();
      chk("ar_pre_en", 32'(oRS_en), 1);
      #2 rst = 1'b0;
      #1;
      chk("ar_en", 32'(oRS_en), 0);
      chk("ar_pc", oRS_pc, 0);
      chk("ar_full", 32'(oRS_full), 0);
      #1 rst = 1'b1;
      iEX_en = 1'b1; iEX_nick = 4'd13; iEX_dt = 32'h13;
      tick();
      tick();
      chk("ar_gone", 32'(oRS_en), 0);
      tick();

      chk("sb_empty", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
